// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NREQ requesters with round-robin grant, ID tagging and drain.
// Define MULT_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module mult_share_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic                    clk,
   input  logic                    clear,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [NREQ-1:0]         req_ready,
   output logic [WIDTH-1:0]        mul_a,
   output logic [WIDTH-1:0]        mul_b,
   input  logic [2*WIDTH-1:0]      mul_prod,
   output logic                    rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [2*WIDTH-1:0]      rsp_prod,
   input  logic                    pause_req,
   output logic                    pause_ack
);
   localparam int unsigned IDW = $clog2(NREQ);

   typedef enum logic [1:0] {StRun, StDrain, StPaused} state_t;

   state_t              r_state, w_state_next;
   logic [NREQ-1:0]     w_grant;
   logic [IDW-1:0]      w_gnt_id;
   logic [WIDTH-1:0]    w_sel_a, w_sel_b;
   logic                w_found, w_xfer, w_busy;
   int unsigned         w_idx;
   logic                r_tag_vld;
   logic [IDW-1:0]      r_tag_id;
   logic [WIDTH-1:0]    r_mul_a, r_mul_b;
   logic                w_al_vld, w_sh_busy;
   logic [IDW-1:0]      w_al_id;
   logic                r_rsp_vld;
   logic [IDW-1:0]      r_rsp_id;
   logic [2*WIDTH-1:0]  r_rsp_prod;
`ifndef MULT_ARB_FIXED_PRIO_EN
   logic [IDW-1:0]      r_ptr;
`endif

   // First valid requester in search order; pause and clear block grants combinationally.
   always_comb begin
      w_grant  = '0;
      w_gnt_id = '0;
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_found  = 1'b0;
      w_idx    = 0;
      if (!clear && !pause_req) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            w_idx = k;
`else
            w_idx = (32'(r_ptr) + k) % NREQ;
`endif
            if (!w_found && req_valid[w_idx]) begin
               w_found          = 1'b1;
               w_grant[w_idx]   = 1'b1;
               w_gnt_id         = IDW'(w_idx);
               w_sel_a          = req_a[w_idx*WIDTH +: WIDTH];
               w_sel_b          = req_b[w_idx*WIDTH +: WIDTH];
            end
         end
      end
   end

   assign req_ready = w_grant;
   assign w_xfer    = |(req_valid & w_grant);

`ifndef MULT_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_ptr <= '0;
      end else if (w_xfer) begin
         r_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
      end
   end
`endif

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_tag_vld <= 1'b0;
         r_tag_id  <= '0;
         r_mul_a   <= '0;
         r_mul_b   <= '0;
      end else begin
         r_tag_vld <= w_xfer;
         r_tag_id  <= w_xfer ? w_gnt_id : '0;
         r_mul_a   <= w_xfer ? w_sel_a : '0;
         r_mul_b   <= w_xfer ? w_sel_b : '0;
      end
   end

   // Tag delay line matching the multiplier's internal register stages.
   if (MUL_LAT == 0) begin : g_no_lat
      assign w_al_vld  = r_tag_vld;
      assign w_al_id   = r_tag_id;
      assign w_sh_busy = 1'b0;
   end else begin : g_lat
      logic [MUL_LAT-1:0] r_sh_vld;
      logic [IDW-1:0]     r_sh_id [MUL_LAT];

      always_ff @(posedge clk or posedge clear) begin
         if (clear) begin
            r_sh_vld <= '0;
            for (int unsigned s = 0; s < MUL_LAT; s++) r_sh_id[s] <= '0;
         end else begin
            r_sh_vld[0] <= r_tag_vld;
            r_sh_id[0]  <= r_tag_id;
            for (int unsigned s = 1; s < MUL_LAT; s++) begin
               r_sh_vld[s] <= r_sh_vld[s-1];
               r_sh_id[s]  <= r_sh_id[s-1];
            end
         end
      end

      assign w_al_vld  = r_sh_vld[MUL_LAT-1];
      assign w_al_id   = r_sh_id[MUL_LAT-1];
      assign w_sh_busy = |r_sh_vld;
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_rsp_vld  <= 1'b0;
         r_rsp_id   <= '0;
         r_rsp_prod <= '0;
      end else begin
         r_rsp_vld  <= w_al_vld;
         r_rsp_id   <= w_al_vld ? w_al_id : '0;
         r_rsp_prod <= w_al_vld ? mul_prod : '0;
      end
   end

   assign w_busy = r_tag_vld | w_sh_busy | r_rsp_vld;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) r_state <= StRun;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StRun: begin
            if (pause_req) w_state_next = StDrain;
         end
         StDrain: begin
            if (!pause_req)   w_state_next = StRun;
            else if (!w_busy) w_state_next = StPaused;
         end
         StPaused: begin
            if (!pause_req) w_state_next = StRun;
         end
         default: w_state_next = StRun;
      endcase
   end

   assign mul_a     = r_mul_a;
   assign mul_b     = r_mul_b;
   assign rsp_valid = r_rsp_vld;
   assign rsp_id    = r_rsp_id;
   assign rsp_prod  = r_rsp_prod;
   assign pause_ack = (r_state == StPaused);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: vector table, directed pause/reset sequences and
// randomized traffic against a queue-based reference model.
module tb_mult_share_arbiter;
   localparam int NREQ    = 4;
   localparam int W       = 4;
   localparam int MUL_LAT = 2;

   logic                clk = 1'b0;
   logic                clear;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*W-1:0]   req_a, req_b;
   logic [NREQ-1:0]     req_ready;
   logic [W-1:0]        mul_a, mul_b;
   logic [2*W-1:0]      mul_prod;
   logic                rsp_valid;
   logic [1:0]          rsp_id;
   logic [2*W-1:0]      rsp_prod;
   logic                pause_req;
   logic                pause_ack;

   mult_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .MUL_LAT(MUL_LAT)) u_dut (
      .clk       (clk),
      .clear     (clear),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_prod  (mul_prod),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_prod  (rsp_prod),
      .pause_req (pause_req),
      .pause_ack (pause_ack)
   );

   always #5 clk = ~clk;

   // External two-stage multiplier
   logic [2*W-1:0] m1 = '0, m2 = '0;
   always_ff @(posedge clk) begin
      m1 <= {4'b0, mul_a} * {4'b0, mul_b};
      m2 <= m1;
   end
   assign mul_prod = m2;

   typedef struct {
      int due;
      int id;
      int prod;
   } exp_t;

   typedef struct {
      logic [NREQ-1:0]   v;
      logic [NREQ*W-1:0] a;
      logic [NREQ*W-1:0] b;
      logic              p;
      logic [NREQ-1:0]   rdy;
   } vec_t;

   exp_t            sq[$];
   vec_t            tbl [16];
   int              checks = 0;
   int              errors = 0;
   int              cyc    = 0;
   int              m_ptr  = 0;
   logic [NREQ-1:0] seen;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, req);
      end
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
         if (v[k]) return k;
`else
         if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
      end
      return -1;
   endfunction

   // One clock: drive at negedge, check grant, then check response #1 after the edge.
   task automatic tick(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                       input logic [NREQ*W-1:0] b, input logic p, output logic [NREQ-1:0] got);
      int              gid;
      logic [NREQ-1:0] erdy;
      logic [10:0]     ersp;
      exp_t            e;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      pause_req = p;
      #1;
      got  = req_ready;
      gid  = p ? -1 : model_pick(v);
      erdy = '0;
      if (gid >= 0) erdy[gid] = 1'b1;
      chk("ready", int'(got), int'(erdy));
      if (gid >= 0) begin
         e.due  = cyc + MUL_LAT + 2;
         e.id   = gid;
         e.prod = int'(a[gid*W +: W]) * int'(b[gid*W +: W]);
         sq.push_back(e);
         m_ptr  = (gid + 1) % NREQ;
      end
      @(posedge clk);
      #1;
      cyc++;
      ersp = '0;
      if (sq.size() > 0 && sq[0].due == cyc) begin
         ersp = {1'b1, 2'(sq[0].id), 8'(sq[0].prod)};
         void'(sq.pop_front());
      end
      chk("rsp", int'({rsp_valid, rsp_id, rsp_prod}), int'(ersp));
      if (!p) chk("ack_low", int'(pause_ack), 0);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [NREQ-1:0]   pend;
      logic [NREQ*W-1:0] ra, rb;
      logic              p;
      int                gid, ack_at, last_due;

      tbl[0]  = '{4'b0100, 16'h0700, 16'h0900, 1'b0, 4'b0100};
      tbl[1]  = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000};
      tbl[2]  = '{4'b1000, 16'hF000, 16'hF000, 1'b0, 4'b1000};
      tbl[3]  = '{4'b0001, 16'h0000, 16'h000F, 1'b0, 4'b0001};
      tbl[4]  = '{4'b1000, 16'h4321, 16'h3333, 1'b0, 4'b1000};
      tbl[5]  = '{4'b1111, 16'h4321, 16'h3333, 1'b0, 4'b0001};
      tbl[6]  = '{4'b1111, 16'h4321, 16'h3333, 1'b0, 4'b0010};
      tbl[7]  = '{4'b1111, 16'h4321, 16'h3333, 1'b0, 4'b0100};
      tbl[8]  = '{4'b1111, 16'h4321, 16'h3333, 1'b0, 4'b1000};
      tbl[9]  = '{4'b1111, 16'h4321, 16'h3333, 1'b0, 4'b0001};
      tbl[10] = '{4'b1111, 16'h4321, 16'h3333, 1'b1, 4'b0000};
      tbl[11] = '{4'b1111, 16'h4321, 16'h3333, 1'b0, 4'b0010};
      tbl[12] = '{4'b0001, 16'h4321, 16'h3333, 1'b0, 4'b0001};
      tbl[13] = '{4'b1001, 16'h4321, 16'h3333, 1'b0, 4'b1000};
      tbl[14] = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000};
      tbl[15] = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000};

      clear     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      pause_req = 1'b0;
      @(negedge clk);
      req_valid = '1;
      #1;
      chk("ready_in_clear", int'(req_ready), 0);
      chk("reset_outputs", int'({mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, pause_ack}), 0);
      @(negedge clk);
      clear     = 1'b0;
      req_valid = '0;

`ifndef MULT_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 16; i++) begin
         tick(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].p, seen);
         chk($sformatf("tbl_ready_%0d", i), int'(seen), int'(tbl[i].rdy));
      end
`else
      for (int i = 0; i < 8; i++) begin
         tick(4'b1010, 16'h5050, 16'h3030, 1'b0, seen);
         chk("fixed_grant", int'(seen), int'(4'b0010));
      end
`endif

      // Pause during a continuous stream, then release
      for (int i = 0; i < 6; i++) tick(4'hF, 16'h4321, 16'h3333, 1'b0, seen);
      tick(4'hF, 16'h4321, 16'h3333, 1'b1, seen);
      chk("pause_blocks", int'(seen), 0);
      last_due = (sq.size() > 0) ? sq[sq.size()-1].due : -1;
      ack_at   = -1;
      for (int i = 0; i < 12; i++) begin
         tick(4'hF, 16'h4321, 16'h3333, 1'b1, seen);
         if (pause_ack && ack_at < 0) ack_at = cyc;
         if (pause_ack && sq.size() > 0) chk("ack_early", 1, 0);
      end
      chk("ack_timing", ack_at, last_due + 2);
      tick(4'hF, 16'h4321, 16'h3333, 1'b0, seen);
      chk("resume_grant", int'(seen != 0), 1);

      // Clear with two operations in flight
      tick(4'hF, 16'h4321, 16'h3333, 1'b0, seen);
      tick(4'hF, 16'h4321, 16'h3333, 1'b0, seen);
      clear     = 1'b1;
      req_valid = 4'hF;
      #1;
      chk("ready_mid_clear", int'(req_ready), 0);
      chk("clear_outputs", int'({mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, pause_ack}), 0);
      @(posedge clk);
      #1;
      cyc++;
      @(negedge clk);
      clear = 1'b0;
      sq.delete();
      m_ptr = 0;
      for (int i = 0; i < 6; i++) tick(4'h0, 16'h0, 16'h0, 1'b0, seen);
      tick(4'b1010, 16'h5050, 16'h3030, 1'b0, seen);
      chk("post_clear_grant", int'(seen), int'(4'b0010));

      // Randomized traffic with operands held until granted
      pend = '0;
      ra   = '0;
      rb   = '0;
      p    = 1'b0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]      = 1'b1;
               ra[i*W +: W] = W'($urandom);
               rb[i*W +: W] = W'($urandom);
            end
         end
         if ($urandom_range(0, 15) == 0) p = ~p;
         gid = p ? -1 : model_pick(pend);
         tick(pend, ra, rb, p, seen);
         if (gid >= 0) pend[gid] = 1'b0;
      end
      for (int i = 0; i < 8; i++) tick(4'h0, 16'h0, 16'h0, 1'b0, seen);
      chk("scoreboard_empty", sq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one pipelined 4x4 Dadda multiplier instance between NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes, issues at most one pair per cycle to the multiplier, and tracks the in-flight requester IDs through the multiplier latency. Each product is returned as a one-cycle response tagged with its requester ID. The block sits between the client logic and the shared multiplier datapath. It also provides a pause/drain handshake so the multiplier can be quiesced.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, operand width in bits
- MUL_LAT, 2, register stages inside the external multiplier, counted from mul_a/mul_b to mul_prod (0 = combinational)

- clk  input  1  clock; all state updates on the rising edge
- clear  input  1  reset, asynchronous, active-high
- req_valid  input  NREQ  requester i has an operand pair pending
- req_a  input  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a
- req_ready  output  NREQ  one-hot or zero; combinational grant
- mul_a  output  WIDTH  registered operand A to the multiplier
- mul_b  output  WIDTH  registered operand B to the multiplier
- mul_prod  input  2*WIDTH  product from the multiplier
- rsp_valid  output  1  one-cycle response strobe
- rsp_id  output  clog2(NREQ)  requester ID of the response
- rsp_prod  output  2*WIDTH  product
- pause_req  input  1  stop granting and drain the pipeline
- pause_ack  output  1  pipeline is empty while paused

## Operation
- **Grant:** req_ready[i] is high when all of the following hold:
  - req_valid[i] is high.
  - pause_req is low.
  - i is the first valid requester found when searching upward from rr_ptr, wrapping modulo NREQ.
- **Transfer and pointer update:** a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge. On a transfer, rr_ptr becomes (i+1) mod NREQ. If there is no transfer, rr_ptr holds.
- **Issue stage:**
  - On a transfer, mul_a/mul_b load the selected operands, and a tag register loads {valid=1, id=i}.
  - With no transfer, mul_a/mul_b load 0 and the tag valid loads 0.
- **Tag pipeline:** the tag passes through MUL_LAT shift stages so that it stays aligned with mul_prod.
- **Response stage:** rsp_valid, rsp_id and rsp_prod register the aligned tag together with mul_prod. rsp_id and rsp_prod are 0 whenever rsp_valid is 0.
- **No backpressure on responses:** the client must accept every rsp_valid strobe.
- **Arithmetic:** the full 2*WIDTH product is passed through unchanged. No truncation.
- **Control FSM states:**
  - RUN: the normal state.
  - DRAIN: entered from RUN when pause_req is sampled high. Grants are already blocked combinationally while pause_req is high.
  - PAUSED: entered from DRAIN when the issue, tag-shift and response stages all hold no valid tag.
  - DRAIN → RUN or PAUSED → RUN: taken when pause_req is sampled low. Grants resume that same cycle, combinationally.
- **pause_ack:** high only in PAUSED.
- **Reset (clear high):**
  - Output values: mul_a, mul_b, rsp_valid, rsp_id, rsp_prod and pause_ack are all 0.
  - State: rr_ptr is 0, all tags are invalid, and the FSM is in RUN.
  - Reset mid-operation discards all in-flight tags. No response is emitted for them.
- **Outputs while clear is high:** req_ready stays low, independent of req_valid.

## Timing
- **Latency:** transfer at edge k → mul_a/mul_b valid in cycle k+1 → mul_prod valid in cycle k+1+MUL_LAT → rsp_valid high in cycle k+2+MUL_LAT.
- **Throughput:** one transfer per cycle, sustained. Responses emerge in grant order, one per cycle, with no gaps other than idle issue slots.
- **Simultaneous requests:** exactly one requester is granted per cycle. Under continuous requests from all NREQ requesters, each is granted once every NREQ cycles.
- **Pointer wrap:** after a grant to NREQ-1, rr_ptr becomes 0.
- **pause_req and req_valid rising together:** there is no grant in that cycle.
- **pause_ack timing:** pause_ack rises no earlier than MUL_LAT+3 cycles after the last transfer. Its earliest assertion is the cycle after the response stage empties.
- **Requester behaviour:** a requester may hold req_valid high across cycles. Its operands must stay stable until the transfer occurs.

## Configuration
- **MULT_ARB_FIXED_PRIO_EN defined:**
  - Fixed priority: the lowest index with req_valid is granted.
  - rr_ptr is not implemented.
  - Starvation of high indices is allowed.
- **MULT_ARB_FIXED_PRIO_EN undefined:** round-robin as described above. This is the default.

## Test plan
- **Single request, latency:** after reset, requester 2 presents a=4'd7, b=4'd9 for one transfer → rsp_valid pulses in cycle k+2+MUL_LAT with rsp_id=2 and rsp_prod=8'd63. No other rsp_valid pulses.
- **All requesters, round-robin:** all 4 requesters hold valid with a=i+1, b=4'd3 → grant order 0,1,2,3,0,… and responses 3,6,9,12 tagged 0..3 on consecutive cycles.
- **Boundary values and pointer wrap:** requester 3 sends a=b=4'hF, then requester 0 sends a=4'h0, b=4'hF → products 8'd225 then 8'd0. rr_ptr wraps to 0, then to 1.
- **Pause and drain:** pause_req is raised during a stream of continuous transfers → req_ready drops that cycle, in-flight responses still arrive, and pause_ack rises after the last response. Lowering pause_req resumes grants in the same cycle.
- **Reset mid-flight:** clear is pulsed for one cycle with 2 operations in flight → no rsp_valid after clear, all outputs 0, and the next grant goes to the lowest valid index.
- **Fixed priority (MULT_ARB_FIXED_PRIO_EN defined):** requesters 1 and 3 are held valid continuously → requester 1 is granted every cycle and requester 3 is never granted.
